// File: rtl/wb_slave_ram64.sv
// wb_slave_ram64 -- Wishbone classic slave backing a 64-bit RAM window.
//
// Sits behind the debug-path 64-bit master. A request (cyc_i & stb_i) is
// latched in IDLE, optionally delayed by WAIT_STATES cycles, committed
// (RAM write or read into data_o) on the edge that raises ack_o, and the
// ack plus read data are then held until the master drops the strobe.
//
// Optional feature macro: WB_SLAVE_RAM64_ERR_EN
//   defined   -> adds err_o; out-of-range accesses answer with err_o
//                instead of ack_o and do not update data_o.
//   undefined -> no err_o; out-of-range accesses are acked.
//
// Ports:
//   clk_i, rst_i      clock, asynchronous active-high reset
//   addr_i[31:0]      byte address (bits [2:0] ignored)
//   data_i[63:0]      write data
//   we_i              1 = write
//   cyc_i, stb_i      bus cycle / strobe
//   data_o[63:0]      read data, held until the next read commit
//   ack_o             transfer acknowledge
//   oor_sticky_o      set by any out-of-range access, cleared by reset
//   err_o             error acknowledge (only with WB_SLAVE_RAM64_ERR_EN)
module wb_slave_ram64 #(
    parameter int          DEPTH          = 16,
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
    parameter int          WAIT_STATES    = 0,
    parameter logic [63:0] OOR_READ_VALUE = 64'hDEAD_BEEF_DEAD_BEEF
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] addr_i,
    input  logic [63:0] data_i,
    input  logic        we_i,
    input  logic        cyc_i,
    input  logic        stb_i,
    output logic [63:0] data_o,
    output logic        ack_o,
    output logic        oor_sticky_o
`ifdef WB_SLAVE_RAM64_ERR_EN
    ,
    output logic        err_o
`endif
);

    localparam int AW = $clog2(DEPTH);
    // One bit wider than the address so BASE_ADDR + DEPTH*8 cannot wrap.
    localparam logic [32:0] LIMIT = {1'b0, BASE_ADDR} + 33'(DEPTH) * 33'd8;

`ifdef WB_SLAVE_RAM64_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    // Parameter sanity checks, flagged at elaboration.
    generate
        if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_bad_ws
            $error("wb_slave_ram64: WAIT_STATES must be in 0..15");
        end
        if (DEPTH < 2 || DEPTH > 1024 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $error("wb_slave_ram64: DEPTH must be a power of two in 2..1024");
        end
        if (BASE_ADDR[2:0] != 3'b000) begin : g_bad_base
            $error("wb_slave_ram64: BASE_ADDR must be 8-byte aligned");
        end
    endgenerate

    // S_ACK is the single commit cycle; ack_o rises on the edge leaving it.
    // S_HOLD keeps ack_o high until the strobe drops.
    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACK,
        S_HOLD
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [AW-1:0]   idx_q;
    logic [63:0]     wdata_q;
    logic            we_q;
    logic            inr_q;

    logic [63:0]     mem [DEPTH];

    logic            req;
    logic            in_range;
    logic [31:0]     offset;
    logic [AW-1:0]   idx_d;
    logic            accept;
    logic            commit;
    logic            ack_d;
    logic            err_d;
    logic            unused_bits;

    assign req         = cyc_i & stb_i;
    assign in_range    = ({1'b0, addr_i} >= {1'b0, BASE_ADDR}) && ({1'b0, addr_i} < LIMIT);
    assign offset      = addr_i - BASE_ADDR;
    assign idx_d       = offset[AW+2:3];
    // Byte lane bits and bits above the window only matter via in_range.
    assign unused_bits = ^{offset[31:AW+3], offset[2:0]};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        commit  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (req) begin
                    accept  = 1'b1;
                    cnt_d   = 4'(WAIT_STATES);
                    state_d = (WAIT_STATES == 0) ? S_ACK : S_WAIT;
                end
            end
            S_WAIT: begin
                if (!req) begin
                    state_d = S_IDLE;           // abort: nothing committed
                end else if (cnt_q == 4'd1) begin
                    cnt_d   = 4'd0;
                    state_d = S_ACK;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_ACK: begin
                if (!req) begin
                    state_d = S_IDLE;           // master left before the ack
                end else begin
                    commit  = 1'b1;
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (!req) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Response flags follow the next state so they rise with the commit and
    // fall on the first edge that sees the strobe low.
    assign ack_d = (state_d == S_HOLD) && (inr_q || !ERR_EN);
    assign err_d = (state_d == S_HOLD) && !inr_q && ERR_EN;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            cnt_q        <= 4'd0;
            idx_q        <= '0;
            wdata_q      <= 64'd0;
            we_q         <= 1'b0;
            inr_q        <= 1'b0;
            data_o       <= 64'd0;
            ack_o        <= 1'b0;
            oor_sticky_o <= 1'b0;
`ifdef WB_SLAVE_RAM64_ERR_EN
            err_o        <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ack_o   <= ack_d;
`ifdef WB_SLAVE_RAM64_ERR_EN
            err_o   <= err_d;
`endif
            if (accept) begin
                idx_q   <= idx_d;
                wdata_q <= data_i;
                we_q    <= we_i;
                inr_q   <= in_range;
            end
            // Reads update data_o; with the error response an out-of-range
            // read leaves it alone.
            if (commit && !we_q && (inr_q || !ERR_EN))
                data_o <= inr_q ? mem[idx_q] : OOR_READ_VALUE;
            if (commit && !inr_q)
                oor_sticky_o <= 1'b1;
        end
    end

    // RAM contents survive reset.
    always_ff @(posedge clk_i) begin
        if (commit && we_q && inr_q)
            mem[idx_q] <= wdata_q;
    end

    logic unused_err;
    assign unused_err = err_d;

endmodule

// File: tb/tb_wb_slave_ram64.sv
// Randomized bench for wb_slave_ram64. Two instances (0 and 3 wait states)
// share clock and reset; a word-array reference model predicts RAM contents,
// data_o, the sticky flag and ack latency.
module tb_wb_slave_ram64;

    localparam int          DEPTH = 16;
    localparam logic [31:0] BASE  = 32'h0000_1000;
    localparam logic [63:0] OOR   = 64'hDEAD_BEEF_DEAD_BEEF;
`ifdef WB_SLAVE_RAM64_ERR_EN
    localparam bit ERR = 1'b1;
`else
    localparam bit ERR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [1:0][31:0] addr;
    logic [1:0][63:0] wdat;
    logic [1:0]       we;
    logic [1:0]       cyc;
    logic [1:0]       stb;
    logic [1:0][63:0] rdat;
    logic [1:0]       ack;
    logic [1:0]       sticky;
    logic [1:0]       err_w;

    wb_slave_ram64 #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .WAIT_STATES(0), .OOR_READ_VALUE(OOR)) u_dut0 (
        .clk_i(clk), .rst_i(rst), .addr_i(addr[0]), .data_i(wdat[0]), .we_i(we[0]),
        .cyc_i(cyc[0]), .stb_i(stb[0]), .data_o(rdat[0]), .ack_o(ack[0]),
        .oor_sticky_o(sticky[0])
`ifdef WB_SLAVE_RAM64_ERR_EN
        , .err_o(err_w[0])
`endif
    );

    wb_slave_ram64 #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .WAIT_STATES(3), .OOR_READ_VALUE(OOR)) u_dut3 (
        .clk_i(clk), .rst_i(rst), .addr_i(addr[1]), .data_i(wdat[1]), .we_i(we[1]),
        .cyc_i(cyc[1]), .stb_i(stb[1]), .data_o(rdat[1]), .ack_o(ack[1]),
        .oor_sticky_o(sticky[1])
`ifdef WB_SLAVE_RAM64_ERR_EN
        , .err_o(err_w[1])
`endif
    );

`ifndef WB_SLAVE_RAM64_ERR_EN
    assign err_w = 2'b00;
`endif

    // Reference model
    logic [63:0] ref_mem [2][DEPTH];
    logic [63:0] ref_data [2];
    bit          ref_sticky [2];

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int ws_of(input int d);
        return (d == 0) ? 0 : 3;
    endfunction

    function automatic bit in_rng(input logic [31:0] a);
        longint la;
        la = longint'({32'd0, a});
        return (la >= longint'({32'd0, BASE})) && (la < longint'({32'd0, BASE}) + DEPTH * 8);
    endfunction

    function automatic int word_of(input logic [31:0] a);
        return int'((longint'({32'd0, a}) - longint'({32'd0, BASE})) / 8);
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic check_outs(input int d, input string tag);
        chk({tag, "_ack"}, {63'd0, ack[d]}, 64'd0);
        chk({tag, "_data"}, rdat[d], ref_data[d]);
        chk({tag, "_sticky"}, {63'd0, sticky[d]}, {63'd0, ref_sticky[d]});
    endtask

    // One complete transfer: checks latency, response, data, then holds the
    // strobe for 'hold' extra cycles and checks the release.
    task automatic txn(input int d, input logic [31:0] a, input logic w,
                       input logic [63:0] wd, input int hold);
        int  k;
        bit  inr;
        int  idx;
        inr = in_rng(a);
        idx = inr ? word_of(a) : 0;
        cyc[d] = 1'b1; stb[d] = 1'b1; addr[d] = a; we[d] = w; wdat[d] = wd;
        k = 0;
        do begin
            step();
            k++;
            if (k == 1) begin
                // bus changes after acceptance must be ignored
                addr[d] = $urandom;
                wdat[d] = {$urandom, $urandom};
                we[d]   = 1'($urandom);
            end
        end while (!(ack[d] | err_w[d]) && k < 40);
        chk("latency", 64'(k), 64'(2 + ws_of(d)));

        if (w && inr) ref_mem[d][idx] = wd;
        if (!w) begin
            if (inr)       ref_data[d] = ref_mem[d][idx];
            else if (!ERR) ref_data[d] = OOR;
        end
        if (!inr) ref_sticky[d] = 1'b1;

        chk("ack", {63'd0, ack[d]}, {63'd0, (inr || !ERR)});
        chk("err", {63'd0, err_w[d]}, {63'd0, (!inr && ERR)});
        chk("rdata", rdat[d], ref_data[d]);
        chk("sticky", {63'd0, sticky[d]}, {63'd0, ref_sticky[d]});
        for (int h = 0; h < hold; h++) begin
            step();
            chk("hold_resp", {63'd0, (ack[d] | err_w[d])}, 64'd1);
            chk("hold_data", rdat[d], ref_data[d]);
        end
        cyc[d] = 1'b0; stb[d] = 1'b0;
        step();
        chk("release_ack", {63'd0, ack[d]}, 64'd0);
        chk("release_err", {63'd0, err_w[d]}, 64'd0);
    endtask

    // Request dropped after 'edges' edges: nothing may be committed.
    task automatic abort_txn(input int d, input logic [31:0] a, input logic w,
                             input logic [63:0] wd, input int edges);
        cyc[d] = 1'b1; stb[d] = 1'b1; addr[d] = a; we[d] = w; wdat[d] = wd;
        for (int e = 0; e < edges; e++) begin
            step();
            chk("abort_noack", {63'd0, ack[d]}, 64'd0);
        end
        cyc[d] = 1'b0; stb[d] = 1'b0;
        for (int e = 0; e < 6; e++) begin
            step();
            check_outs(d, "abort");
        end
    endtask

    task automatic do_reset_model;
        for (int d = 0; d < 2; d++) begin
            ref_data[d]   = 64'd0;
            ref_sticky[d] = 1'b0;
        end
    endtask

    function automatic logic [31:0] rand_addr(input bit oor);
        logic [31:0] a;
        if (!oor) begin
            a = BASE + 32'($urandom_range(0, DEPTH - 1)) * 32'd8 + 32'($urandom_range(0, 7));
        end else begin
            case ($urandom_range(0, 3))
                0: a = BASE - 32'd8;
                1: a = BASE - 32'd1;
                2: a = BASE + DEPTH * 8 + 32'($urandom_range(0, 255));
                default: a = 32'hFFFF_FFF8;
            endcase
        end
        return a;
    endfunction

    initial begin
        addr = '0; wdat = '0; we = '0; cyc = '0; stb = '0;
        do_reset_model();
        repeat (3) step();
        rst = 1'b0;

        // Reset state, idle bus
        for (int c = 0; c < 10; c++) begin
            step();
            for (int d = 0; d < 2; d++) check_outs(d, "idle");
        end

        // Fill both RAMs so the model is fully defined
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < DEPTH; i++)
                txn(d, BASE + 32'(i * 8), 1'b1, {$urandom, $urandom}, 0);

        // Directed write/read, zero wait states
        txn(0, BASE + 32'd8, 1'b1, 64'h0123_4567_89AB_CDEF, 0);
        txn(0, BASE + 32'd8, 1'b0, 64'd0, 2);
        chk("raw_word1", rdat[0], 64'h0123_4567_89AB_CDEF);

        // Wait states: read word 0, then aborted read and aborted write
        txn(1, BASE, 1'b0, 64'd0, 0);
        abort_txn(1, BASE + 32'd8, 1'b0, 64'd0, 2);
        abort_txn(1, BASE + 32'd16, 1'b1, 64'h5555_AAAA_5555_AAAA, 2);
        txn(1, BASE + 32'd16, 1'b0, 64'd0, 0);

        // Out of range read at the first address past the window, OOR write
        txn(0, BASE + DEPTH * 8, 1'b0, 64'd0, 1);
        txn(0, BASE - 32'd8, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 0);

        // Held strobe: five extra cycles with ack high
        txn(1, BASE + 32'd24, 1'b1, 64'hCAFE_F00D_1234_5678, 5);
        txn(1, BASE + 32'd24, 1'b0, 64'd0, 0);

        // Reset during WAIT of a write to word 2: write discarded
        cyc[1] = 1'b1; stb[1] = 1'b1; addr[1] = BASE + 32'd16; we[1] = 1'b1;
        wdat[1] = 64'hFFFF_FFFF_FFFF_FFFF;
        step(); step();
        rst = 1'b1;
        #1;
        chk("rst_wait_ack", {63'd0, ack[1]}, 64'd0);
        cyc[1] = 1'b0; stb[1] = 1'b0;
        step();
        rst = 1'b0;
        do_reset_model();
        for (int d = 0; d < 2; d++) check_outs(d, "post_rst");
        txn(1, BASE + 32'd16, 1'b0, 64'd0, 0);

        // Reset while ack is held: ack drops without a clock edge
        cyc[1] = 1'b1; stb[1] = 1'b1; addr[1] = BASE + 32'd8; we[1] = 1'b0;
        repeat (5) step();
        chk("pre_rst_ack", {63'd0, ack[1]}, 64'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_hold_ack", {63'd0, ack[1]}, 64'd0);
        cyc[1] = 1'b0; stb[1] = 1'b0;
        step();
        rst = 1'b0;
        do_reset_model();
        step();
        for (int d = 0; d < 2; d++) check_outs(d, "post_rst2");

        // Random traffic
        for (int n = 0; n < 120; n++) begin
            for (int d = 0; d < 2; d++) begin
                bit oor;
                oor = ($urandom_range(0, 7) == 0);
                txn(d, rand_addr(oor), 1'($urandom), {$urandom, $urandom}, $urandom_range(0, 3));
            end
        end

        // Final sweep of every word
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < DEPTH; i++)
                txn(d, BASE + 32'(i * 8), 1'b0, 64'd0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
